// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} state_t;
  localparam int WORDSIZE_DEF = 64;
  localparam int INSTRUCTION_SIZE_DEF = 32;
  localparam int INSTR_BYTES = INSTRUCTION_SIZE_DEF / 8;
  typedef struct packed {
    logic [WORDSIZE_DEF-1:0] pc;
    logic [INSTRUCTION_SIZE_DEF-1:0] instr;
  } entry_t;
  function automatic int instr_bytes(input int isize);
    return isize / 8;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush; flush beats push and pop
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, one-outstanding imem requester, prefetch queue and redirect handling
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid,
  output logic [WORDSIZE-1:0]         imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_resp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_resp_instr,
  input  logic                        redirect_valid,
  input  logic [WORDSIZE-1:0]         redirect_target,
  output logic                        instr_valid,
  output logic [INSTRUCTION_SIZE-1:0] instr,
  output logic [WORDSIZE-1:0]         instr_pc,
  input  logic                        instr_ready,
  output logic                        fetch_fault
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int EW = WORDSIZE + INSTRUCTION_SIZE;
  localparam int STEP = instr_bytes(INSTRUCTION_SIZE);
  state_t state_q, state_d;
  logic [WORDSIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic out_q, out_d, drop_q, drop_d;
  logic [AW:0] q_count;
  logic q_full, q_empty;
  logic [EW-1:0] q_head;
  logic hs, resp, redir, aligned, out_now, push, pop;
  always_comb begin
    imem_req_valid = state_q == REQ && !q_full &&
                     ({1'b0, q_count} + (AW+2)'(out_q) < (AW+2)'(QUEUE_DEPTH));
    imem_req_addr = fetch_pc_q;
    hs = imem_req_valid && imem_req_ready;
    resp = imem_resp_valid && out_q;
    redir = redirect_valid && state_q != IDLE;
    aligned = redirect_target[1:0] == 2'b00;
    out_now = hs || (out_q && !resp);
    push = state_q == WAIT && resp && !drop_q;
    instr_valid = !q_empty;
    instr = q_empty ? '0 : q_head[INSTRUCTION_SIZE-1:0];
    instr_pc = q_empty ? '0 : q_head[EW-1 -: WORDSIZE];
    pop = instr_valid && instr_ready;
    fetch_fault = state_q == FAULT;
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d = out_now;
    drop_d = drop_q && !resp;
    // a request still in flight after this edge must have its response discarded
    if (redir) begin
      state_d = !aligned ? FAULT : out_now ? WAIT : REQ;
      fetch_pc_d = aligned ? redirect_target : fetch_pc_q;
      drop_d = out_now;
    end else if (state_q == IDLE) state_d = REQ;
    else if (hs) begin
      state_d = WAIT;
      fetch_pc_d = fetch_pc_q + WORDSIZE'(STEP);
    end else if (state_q == WAIT && resp) state_d = REQ;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      out_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  fetch_queue #(.DEPTH(QUEUE_DEPTH), .W(EW)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({fetch_pc_q - WORDSIZE'(STEP), imem_resp_instr}),
    .pop(pop),
    .flush(redir),
    .dout(q_head),
    .count(q_count),
    .full(q_full),
    .empty(q_empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a one-cycle-latency memory responder
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  logic imem_req_valid;
  logic [63:0] imem_req_addr;
  logic imem_req_ready;
  logic imem_resp_valid;
  logic [31:0] imem_resp_instr;
  logic redirect_valid;
  logic [63:0] redirect_target;
  logic instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic instr_ready;
  logic fetch_fault;
  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_instr(imem_resp_instr),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // advance one clock; a request accepted at this edge is answered during the next cycle
  task automatic tick();
    logic h;
    logic [63:0] a;
    @(negedge clk);
    h = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = h;
    imem_resp_instr = h ? mk(a) : 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_instr = '0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);

    rst = 1'b0;
    tick();
    chk("p1_req_valid", imem_req_valid, 1);
    chk("p1_req_addr0", imem_req_addr, 64'h0);
    chk("p1_iv_early", instr_valid, 0);
    tick();
    chk("p1_wait_req_valid", imem_req_valid, 0);
    chk("p1_iv_wait", instr_valid, 0);
    tick();
    chk("p1_iv_first", instr_valid, 1);
    chk("p1_pc0", instr_pc, 64'h0);
    chk("p1_instr0", instr, mk(64'h0));
    chk("p1_req_addr4", imem_req_addr, 64'h4);
    tick();
    tick();
    chk("p1_pc4", instr_pc, 64'h4);
    chk("p1_instr4", instr, mk(64'h4));
    tick();
    tick();
    chk("p1_pc8", instr_pc, 64'h8);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_ready = 1'b0;
    repeat (9) tick();
    chk("p2_full_req_valid", imem_req_valid, 0);
    chk("p2_full_iv", instr_valid, 1);
    chk("p2_full_head", instr_pc, 64'h0);
    repeat (2) tick();
    chk("p2_stall_req_valid", imem_req_valid, 0);
    chk("p2_stall_head", instr_pc, 64'h0);
    instr_ready = 1'b1;
    tick();
    chk("p2_drain_pc4", instr_pc, 64'h4);
    chk("p2_resume_valid", imem_req_valid, 1);
    chk("p2_resume_addr", imem_req_addr, 64'h10);
    tick();
    chk("p2_drain_pc8", instr_pc, 64'h8);
    tick();
    chk("p2_drain_pcc", instr_pc, 64'hC);
    chk("p2_drain_instrc", instr, mk(64'hC));
    tick();
    chk("p2_pc10", instr_pc, 64'h10);

    imem_resp_valid = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 64'h100;
    tick();
    redirect_valid = 1'b0;
    chk("p3_flush_iv", instr_valid, 0);
    chk("p3_wait_req_valid", imem_req_valid, 0);
    imem_resp_valid = 1'b1;
    imem_resp_instr = 32'hDEAD_BEEF;
    tick();
    chk("p3_stale_iv", instr_valid, 0);
    chk("p3_req_valid", imem_req_valid, 1);
    chk("p3_req_addr", imem_req_addr, 64'h100);
    tick();
    tick();
    chk("p3_iv", instr_valid, 1);
    chk("p3_pc", instr_pc, 64'h100);
    chk("p3_instr", instr, mk(64'h100));

    redirect_valid = 1'b1;
    redirect_target = 64'h102;
    tick();
    redirect_valid = 1'b0;
    chk("p4_fault", fetch_fault, 1);
    chk("p4_req_valid", imem_req_valid, 0);
    chk("p4_iv", instr_valid, 0);
    tick();
    chk("p4_fault_hold", fetch_fault, 1);
    chk("p4_resp_dropped_iv", instr_valid, 0);
    chk("p4_hold_req_valid", imem_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_target = 64'h200;
    tick();
    redirect_valid = 1'b0;
    chk("p4_fault_clear", fetch_fault, 0);
    chk("p4_resume_valid", imem_req_valid, 1);
    chk("p4_resume_addr", imem_req_addr, 64'h200);
    tick();
    tick();
    chk("p4_pc", instr_pc, 64'h200);

    tick();
    imem_resp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("p5_async_req_valid", imem_req_valid, 0);
    chk("p5_async_req_addr", imem_req_addr, 64'h0);
    chk("p5_async_iv", instr_valid, 0);
    chk("p5_async_fault", fetch_fault, 0);
    chk("p5_async_instr", instr, 0);
    chk("p5_async_pc", instr_pc, 0);
    imem_resp_valid = 1'b1;
    imem_resp_instr = 32'hBAD0_0BAD;
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_instr = 32'hBAD0_0BAD;
    tick();
    chk("p5_ignored_iv", instr_valid, 0);
    chk("p5_restart_valid", imem_req_valid, 1);
    chk("p5_restart_addr", imem_req_addr, 64'h0);
    tick();
    tick();
    chk("p5_pc", instr_pc, 64'h0);
    chk("p5_instr", instr, mk(64'h0));

    redirect_valid = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("p6_wait_req_valid", imem_req_valid, 0);
    tick();
    chk("p6_req_valid", imem_req_valid, 1);
    chk("p6_req_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    chk("p6_pc_top", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("p6_instr_top", instr, 32'hC0DE_FFFC);
    chk("p6_wrap_valid", imem_req_valid, 1);
    chk("p6_wrap_addr", imem_req_addr, 64'h0);

    instr_ready = 1'b0;
    tick();
    tick();
    chk("p7_two_queued", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 64'h300;
    tick();
    redirect_valid = 1'b0;
    chk("p7_flush_iv", instr_valid, 0);
    chk("p7_flush_instr", instr, 0);
    chk("p7_flush_pc", instr_pc, 0);
    repeat (3) tick();
    chk("p7_pc", instr_pc, 64'h300);
    chk("p7_iv", instr_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
